ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single B port of the frame/board dual-port RAM between two requesters: the VGA pixel fetch path (requester 0, read-only, latency-critical) and a host/debug path (requester 1, read/write). It grants one access per cycle with fixed priority to VGA plus a starvation guard for the host. It tracks in-flight reads through the RAM latency and routes `q_b` back to the owning requester with a per-requester `rvalid` strobe. It sits between `draw_board`-style fetch logic and the RAM's `address_b`/`byteena_b`/`q_b` pins.

## Interface
Parameters:
- `AW` (default 17): RAM word-address width.
- `DW` (default 32): RAM data width.
- `RD_LATENCY` (default 2): cycles from a registered `address_b` change to valid `q_b`; legal range 1..4.
- `STARVE_MAX` (default 8): number of consecutive denied cycles of requester 1 before it is forced a slot; legal range 1..255.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-low reset.
- `req0`  in  1  VGA read request; held high with `addr0` stable until `gnt0`.
- `addr0`  in  AW  VGA read address.
- `gnt0`  out  1  combinational grant to requester 0 in the accepting cycle.
- `rvalid0`  out  1  one-cycle strobe: `rdata0` valid.
- `rdata0`  out  DW  read data for requester 0.
- `req1`  in  1  host request; held with `we1`/`addr1`/`wdata1`/`be1` stable until `gnt1`.
- `we1`  in  1  1 = write, 0 = read.
- `addr1`  in  AW  host address.
- `wdata1`  in  DW  host write data.
- `be1`  in  4  host byte enables for writes.
- `gnt1`  out  1  combinational grant to requester 1.
- `rvalid1`  out  1  one-cycle strobe: `rdata1` valid (reads only).
- `rdata1`  out  DW  read data for requester 1.
- `address_b`  out  AW  registered RAM port-B address.
- `byteena_b`  out  4  registered RAM port-B byte enables.
- `wren_b`  out  1  registered RAM port-B write enable.
- `data_b`  out  DW  registered RAM port-B write data.
- `q_b`  in  DW  RAM port-B read data.

## Operation
- Arbitration happens in the same cycle as the request, combinationally from `req0`, `req1` and `starve_cnt`:
  - `force1 = req1 && starve_cnt == STARVE_MAX`.
  - `gnt1 = req1 && (!req0 || force1)`.
  - `gnt0 = req0 && !gnt1`.
  - At most one grant per cycle.
- `starve_cnt` (8 bits):
  - Increments when `req1 && !gnt1`.
  - Clears on `gnt1` or when `!req1`.
  - Saturates at `STARVE_MAX`.
- On grant, the RAM pins are registered at the next edge:
  - `address_b` takes the granted address.
  - `wren_b` takes `gnt1 && we1`.
  - `data_b` takes `wdata1` on a host write; otherwise it holds.
  - `byteena_b` takes `be1` on a host write; otherwise `4'hF`.
- No grant: `wren_b` = 0; `address_b`, `data_b` and `byteena_b` hold.
- Tag pipeline (depth `RD_LATENCY`+1): each stage holds {valid, owner}. A read grant enters {1, requester id}; a write or idle cycle enters {0, x}.
- When the last stage is valid:
  - Capture `q_b` into `rdata<owner>`.
  - Pulse `rvalid<owner>` for 1 cycle.
  - `rdata0`/`rdata1` hold between strobes.
- Reads complete in grant order; there is no reordering.
- Throughput: 1 access per cycle, sustained back-to-back.

## Timing
- Grant at cycle t: RAM pins update at t+1; `rvalid` and `rdata` are valid during cycle t+1+`RD_LATENCY` (t+3 at default).
- Write at cycle t: `wren_b`=1 for exactly cycle t+1; produces no `rvalid`.
- Reset (`reset`=0 at an edge), applied in any state:
  - `address_b`=0, `byteena_b`=4'hF, `wren_b`=0, `data_b`=0.
  - `rvalid0`=`rvalid1`=0, `rdata0`=`rdata1`=0.
  - `starve_cnt`=0; all tag stages are invalidated.
- `gnt0`/`gnt1` are forced 0 while `reset`=0.
- Reset mid-operation drops in-flight reads: no `rvalid` appears after reset for reads granted before it.
- Simultaneous `req0`/`req1` with `starve_cnt` < `STARVE_MAX`: requester 0 wins.
- With `starve_cnt` == `STARVE_MAX`: requester 1 wins for exactly one cycle, then requester 0 resumes.
- Deasserting `req1` before its grant is legal and clears `starve_cnt`.
- Requesters must not drop `req` or change the payload before the grant; behaviour in that case is undefined.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with both requests high. Required: no grants, all outputs at reset values, `byteena_b`=4'hF.
- Single VGA read: `req0`=1, `addr0`=17'h00123 at cycle 0. Required: `gnt0`=1 at cycle 0, `address_b`=17'h00123 at cycle 1, `rvalid0`=1 with `rdata0` = `q_b` at cycle 3, `rvalid1` never asserted.
- Host write: `req1`=1, `we1`=1, `addr1`=17'h1FFFF, `wdata1`=32'hDEADBEEF, `be1`=4'b0101. Required: `wren_b`=1 for exactly one cycle with those address, data and enables; no `rvalid`.
- Starvation: `req0` held continuously, `req1` read raised at cycle 0. Required: `gnt1` at cycle 8, `gnt0` at cycles 0-7 and 9+, `rvalid1` at cycle 11.
- Interleaved reads: alternate grants 0,1,0,1 back-to-back with the RAM model returning the address as data. Required: four strobes in order, each `rdata` equal to its own address.
- Reset mid-flight: grant a read at cycle 0, pulse `reset`=0 at cycle 1. Required: no `rvalid` at cycles 3-4; a normal read after reset completes correctly.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares RAM port B between the VGA fetch path (0) and the host/debug path (1).
// Fixed priority to VGA with a starvation guard for the host; read data routed back by tag.
module ram_port_arbiter #(
   parameter int unsigned AW         = 17,
   parameter int unsigned DW         = 32,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   input  logic [3:0]    be1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] address_b,
   output logic [3:0]    byteena_b,
   output logic          wren_b,
   output logic [DW-1:0] data_b,
   input  logic [DW-1:0] q_b
);

   localparam int unsigned Depth = RD_LATENCY + 1;

   logic [7:0]       starve_cnt_q, starve_cnt_d;
   logic             force1;
   logic [AW-1:0]    address_q, address_d;
   logic [3:0]       byteena_q, byteena_d;
   logic             wren_q, wren_d;
   logic [DW-1:0]    data_q, data_d;
   logic [Depth-1:0] tag_valid_q, tag_owner_q;
   logic             rd_grant;
   logic [DW-1:0]    rdata0_q, rdata1_q;

   // Grants are masked during reset so no access can slip through.
   always_comb begin
      force1 = req1 && (starve_cnt_q == 8'(STARVE_MAX));
      gnt1   = reset && req1 && (!req0 || force1);
      gnt0   = reset && req0 && !gnt1;
      starve_cnt_d = starve_cnt_q;
      if (gnt1 || !req1) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < 8'(STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   always_comb begin
      address_d = address_q;
      byteena_d = byteena_q;
      data_d    = data_q;
      wren_d    = 1'b0;
      if (gnt1) begin
         address_d = addr1;
         wren_d    = we1;
         byteena_d = we1 ? be1 : 4'hF;
         if (we1) data_d = wdata1;
      end else if (gnt0) begin
         address_d = addr0;
         byteena_d = 4'hF;
      end
   end

   assign rd_grant = gnt0 || (gnt1 && !we1);

   // The last tag stage lines up with q_b, so the data is forwarded in the same cycle.
   always_comb begin
      rvalid0 = tag_valid_q[Depth-1] && !tag_owner_q[Depth-1];
      rvalid1 = tag_valid_q[Depth-1] && tag_owner_q[Depth-1];
      rdata0  = rvalid0 ? q_b : rdata0_q;
      rdata1  = rvalid1 ? q_b : rdata1_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt_q <= '0;
         address_q    <= '0;
         byteena_q    <= 4'hF;
         wren_q       <= 1'b0;
         data_q       <= '0;
         tag_valid_q  <= '0;
         tag_owner_q  <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         address_q    <= address_d;
         byteena_q    <= byteena_d;
         wren_q       <= wren_d;
         data_q       <= data_d;
         tag_valid_q  <= {tag_valid_q[Depth-2:0], rd_grant};
         tag_owner_q  <= {tag_owner_q[Depth-2:0], gnt1};
         if (rvalid0) rdata0_q <= q_b;
         if (rvalid1) rdata1_q <= q_b;
      end
   end

   assign address_b = address_q;
   assign byteena_b = byteena_q;
   assign wren_b    = wren_q;
   assign data_b    = data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: per-cycle vectors with expected grants, plus a scoreboard
// of expected read strobes fed from the bench's own grant expectations.
module tb_ram_port_arbiter;

   localparam int unsigned AW         = 17;
   localparam int unsigned DW         = 32;
   localparam int unsigned RD_LATENCY = 2;
   localparam int unsigned STARVE_MAX = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata1;
   logic [3:0]    be1;
   logic          gnt0, gnt1, rvalid0, rvalid1, wren_b;
   logic [DW-1:0] rdata0, rdata1, data_b, q_b;
   logic [AW-1:0] address_b;
   logic [3:0]    byteena_b;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .AW(AW), .DW(DW), .RD_LATENCY(RD_LATENCY), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .address_b(address_b), .byteena_b(byteena_b), .wren_b(wren_b), .data_b(data_b),
      .q_b(q_b)
   );

   // RAM model: returns the zero-extended address RD_LATENCY cycles after address_b.
   logic [AW-1:0] ram_pipe [RD_LATENCY];
   always @(posedge clk) begin
      ram_pipe[0] <= address_b;
      for (int i = 1; i < RD_LATENCY; i++) ram_pipe[i] <= ram_pipe[i-1];
   end
   assign q_b = DW'(ram_pipe[RD_LATENCY-1]);

   typedef struct {
      logic          r0;
      logic [AW-1:0] a0;
      logic          r1;
      logic          we;
      logic [AW-1:0] a1;
      logic [DW-1:0] wd;
      logic [3:0]    be;
      logic          g0;
      logic          g1;
   } vec_t;

   typedef struct {
      logic          owner;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cycle   = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [3:0]    exp_be   = 4'hF;
   logic          exp_wren = 1'b0;
   logic [DW-1:0] exp_data = '0;
   logic [DW-1:0] exp_rd0  = '0;
   logic [DW-1:0] exp_rd1  = '0;
   vec_t          vecs [19];

   function automatic vec_t mk(input logic r0, input logic [AW-1:0] a0, input logic r1,
                               input logic we, input logic [AW-1:0] a1,
                               input logic [DW-1:0] wd, input logic [3:0] be,
                               input logic g0, input logic g1);
      vec_t v;
      v.r0 = r0; v.a0 = a0; v.r1 = r1; v.we = we; v.a1 = a1;
      v.wd = wd; v.be = be; v.g0 = g0; v.g1 = g1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, required %h", name, cycle, act, exp_v);
      end
   endtask

   task automatic check_cycle(input logic g0, input logic g1);
      exp_t e;
      chk("gnt0", 64'(gnt0), 64'(g0));
      chk("gnt1", 64'(gnt1), 64'(g1));
      chk("address_b", 64'(address_b), 64'(exp_addr));
      chk("byteena_b", 64'(byteena_b), 64'(exp_be));
      chk("wren_b", 64'(wren_b), 64'(exp_wren));
      chk("data_b", 64'(data_b), 64'(exp_data));
      if (sb.size() > 0 && sb[0].due == cycle) begin
         e = sb.pop_front();
         chk("rvalid0", 64'(rvalid0), 64'(!e.owner));
         chk("rvalid1", 64'(rvalid1), 64'(e.owner));
         if (e.owner) exp_rd1 = e.data;
         else         exp_rd0 = e.data;
      end else begin
         chk("rvalid0_idle", 64'(rvalid0), 64'(0));
         chk("rvalid1_idle", 64'(rvalid1), 64'(0));
      end
      chk("rdata0", 64'(rdata0), 64'(exp_rd0));
      chk("rdata1", 64'(rdata1), 64'(exp_rd1));
   endtask

   // Called just after a posedge; returns just after the next one.
   task automatic step(input vec_t v);
      reset = 1'b1;
      req0 = v.r0; addr0 = v.a0; req1 = v.r1; we1 = v.we;
      addr1 = v.a1; wdata1 = v.wd; be1 = v.be;
      @(negedge clk);
      check_cycle(v.g0, v.g1);
      exp_wren = 1'b0;
      if (v.g1) begin
         exp_addr = v.a1;
         exp_wren = v.we;
         exp_be   = v.we ? v.be : 4'hF;
         if (v.we) exp_data = v.wd;
         else sb.push_back('{owner: 1'b1, data: DW'(v.a1), due: cycle + 1 + RD_LATENCY});
      end else if (v.g0) begin
         exp_addr = v.a0;
         exp_be   = 4'hF;
         sb.push_back('{owner: 1'b0, data: DW'(v.a0), due: cycle + 1 + RD_LATENCY});
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic apply_reset(input int n);
      for (int i = 0; i < n; i++) begin
         reset = 1'b0;
         req0 = 1'b1; addr0 = 17'h0AAAA; req1 = 1'b1; we1 = 1'b1;
         addr1 = 17'h15555; wdata1 = 32'hCAFEF00D; be1 = 4'h3;
         @(negedge clk);
         check_cycle(1'b0, 1'b0);
         sb.delete();
         exp_addr = '0; exp_be = 4'hF; exp_wren = 1'b0; exp_data = '0;
         exp_rd0 = '0; exp_rd1 = '0;
         @(posedge clk);
         #1;
         cycle++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0));
   endtask

   // VGA requests every cycle; host read raised at cycle 0, optionally dropped for one cycle.
   task automatic starve_run(input int drop_at, input int exp_at, input int len);
      logic [AW-1:0] a0;
      logic          done;
      logic          r1, g1;
      a0   = 17'h01000;
      done = 1'b0;
      for (int k = 0; k < len; k++) begin
         r1 = !done && (k != drop_at);
         g1 = (k == exp_at);
         step(mk(1, a0, r1, 0, 17'h0ABCD, '0, 4'h0, !g1, g1));
         if (g1) done = 1'b1;
         else    a0 = a0 + 17'd1;
      end
      idle(RD_LATENCY + 3);
   endtask

   initial begin
      vecs[0]  = mk(1, 17'h00123, 0, 0, '0, '0, 4'h0, 1, 0);
      vecs[1]  = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[2]  = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[3]  = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[4]  = mk(0, '0, 1, 1, 17'h1FFFF, 32'hDEADBEEF, 4'b0101, 0, 1);
      vecs[5]  = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[6]  = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[7]  = mk(1, 17'h00011, 0, 0, '0, '0, 4'h0, 1, 0);
      vecs[8]  = mk(0, '0, 1, 0, 17'h00022, '0, 4'h0, 0, 1);
      vecs[9]  = mk(1, 17'h00033, 0, 0, '0, '0, 4'h0, 1, 0);
      vecs[10] = mk(0, '0, 1, 0, 17'h00044, '0, 4'h0, 0, 1);
      vecs[11] = mk(1, 17'h00100, 1, 0, 17'h00200, '0, 4'h0, 1, 0);
      vecs[12] = mk(0, '0, 1, 0, 17'h00200, '0, 4'h0, 0, 1);
      vecs[13] = mk(1, 17'h00300, 1, 1, 17'h00400, 32'h12345678, 4'b1100, 1, 0);
      vecs[14] = mk(0, '0, 1, 1, 17'h00400, 32'h12345678, 4'b1100, 0, 1);
      vecs[15] = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[16] = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[17] = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);
      vecs[18] = mk(0, '0, 0, 0, '0, '0, 4'h0, 0, 0);

      reset = 1'b0;
      req0 = 1'b1; addr0 = '0; req1 = 1'b1; we1 = 1'b0;
      addr1 = '0; wdata1 = '0; be1 = 4'h0;
      @(posedge clk);
      #1;
      apply_reset(3);

      for (int i = 0; i < 19; i++) step(vecs[i]);

      starve_run(-1, STARVE_MAX, STARVE_MAX + 6);
      starve_run(5, 6 + STARVE_MAX, STARVE_MAX + 10);

      step(mk(1, 17'h00777, 0, 0, '0, '0, 4'h0, 1, 0));
      apply_reset(1);
      idle(4);
      step(mk(1, 17'h00888, 0, 0, '0, '0, 4'h0, 1, 0));
      idle(RD_LATENCY + 2);

      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
